// File: rtl/bcd_scan_display.sv
// ============================================================================
// Module   : bcd_scan_display
// Purpose  : Shift-in BCD digit buffer time-multiplexed onto a common-anode
//            seven-segment display with leading-zero blanking and overflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_scan_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  logic [3:0]        bcd_in,
  input  logic              bcd_valid,
  input  logic              clear,
  input  logic              blank_lz,
  output logic [6:0]        seg_n,
  output logic [DIGITS-1:0] an_n,
  output logic              ovf
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [3:0]        d_q [DIGITS];
  logic [3:0]        d_d [DIGITS];
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic [DIGITS-1:0] zero_from;
  logic              zacc;
  logic [3:0]        cur_digit;
  logic              blanked;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'd15:   s = 7'b1111111;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // zero_from[i] is set when digit i and every more-significant digit are zero
  always_comb begin
    zacc      = 1'b1;
    zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zacc         = zacc & (d_q[i] == 4'd0);
      zero_from[i] = zacc;
    end
  end

  always_comb begin
    d_d    = d_q;
    ovf_d  = ovf_q;
    pcnt_d = pcnt_q + PW'(1);
    idx_d  = idx_q;

    if (pcnt_q == PW'(SCAN_DIV - 1)) begin
      pcnt_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end

    if (clear) begin
      for (int i = 0; i < DIGITS; i++) d_d[i] = 4'd0;
      ovf_d = 1'b0;
    end else if (bcd_valid) begin
      if (d_q[DIGITS-1] != 4'd0) ovf_d = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) d_d[i] = d_q[i-1];
      d_d[0] = bcd_in;
    end

    cur_digit = d_q[idx_q];
    blanked   = blank_lz && (idx_q != '0) && zero_from[idx_q];
    seg_d     = blanked ? 7'b1111111 : decode(cur_digit);
    an_d      = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      for (int i = 0; i < DIGITS; i++) d_q[i] <= 4'd0;
      ovf_q  <= 1'b0;
      pcnt_q <= '0;
      idx_q  <= '0;
      seg_q  <= 7'b1111111;
      an_q   <= '1;
    end else begin
      d_q    <= d_d;
      ovf_q  <= ovf_d;
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg_n = seg_q;
  assign an_n  = an_q;
  assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
// ============================================================================
// Module   : tb_bcd_scan_display
// Purpose  : Directed plus randomized checks of bcd_scan_display against a
//            time-based behavioural display model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_scan_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic              clk = 1'b0;
  logic              sync_reset = 1'b1;
  logic [3:0]        bcd_in = 4'd0;
  logic              bcd_valid = 1'b0;
  logic              clear = 1'b0;
  logic              blank_lz = 1'b0;
  logic [6:0]        seg_n;
  logic [DIGITS-1:0] an_n;
  logic              ovf;

  bcd_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bcd_in     (bcd_in),
    .bcd_valid  (bcd_valid),
    .clear      (clear),
    .blank_lz   (blank_lz),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: digit values, sticky overflow, and elapsed run cycles since reset
  int m_buf [DIGITS];
  int m_ovf;
  int m_n;
  logic [6:0] seg_tab [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg();
    int  di;
    bit  all_zero;
    di = (m_n / SCAN_DIV) % DIGITS;
    all_zero = 1'b1;
    for (int j = di; j < DIGITS; j++) if (m_buf[j] != 0) all_zero = 1'b0;
    if (blank_lz && di >= 1 && all_zero) return 7'b1111111;
    return seg_tab[m_buf[di]];
  endfunction

  function automatic logic [DIGITS-1:0] model_an();
    int di;
    logic [DIGITS-1:0] a;
    di = (m_n / SCAN_DIV) % DIGITS;
    a = '1;
    a[di] = 1'b0;
    return a;
  endfunction

  // Apply inputs for one clock, predict, clock, and compare
  task automatic step(input bit rst, input bit clr, input bit vld, input int val, input bit blz);
    logic [6:0]        e_seg;
    logic [DIGITS-1:0] e_an;
    sync_reset = rst;
    clear      = clr;
    bcd_valid  = vld;
    bcd_in     = 4'(val);
    blank_lz   = blz;
    if (rst) begin
      e_seg = 7'b1111111;
      e_an  = '1;
      for (int i = 0; i < DIGITS; i++) m_buf[i] = 0;
      m_ovf = 0;
      m_n   = 0;
    end else begin
      e_seg = model_seg();
      e_an  = model_an();
      if (clr) begin
        for (int i = 0; i < DIGITS; i++) m_buf[i] = 0;
        m_ovf = 0;
      end else if (vld) begin
        if (m_buf[DIGITS-1] != 0) m_ovf = 1;
        for (int i = DIGITS - 1; i >= 1; i--) m_buf[i] = m_buf[i-1];
        m_buf[0] = val;
      end
      m_n++;
    end
    @(posedge clk);
    #1;
    chk("seg_n", 32'(seg_n), 32'(e_seg));
    chk("an_n", 32'(an_n), 32'(e_an));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic idle(input int cycles, input bit blz);
    for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, 1'b0, 0, blz);
  endtask

  task automatic strobe(input int val, input bit blz);
    step(1'b0, 1'b0, 1'b1, val, blz);
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b1111111};

    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("reset_an_const", 32'(an_n), 32'hF);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("first_an_const", 32'(an_n), 32'hE);
    chk("first_seg_const", 32'(seg_n), 32'b1000000);
    idle(16, 1'b0);

    strobe(1, 1'b0); strobe(2, 1'b0); strobe(3, 1'b0);
    idle(2 * DIGITS * SCAN_DIV, 1'b0);

    step(1'b0, 1'b1, 1'b0, 0, 1'b1);
    strobe(5, 1'b1);
    idle(DIGITS * SCAN_DIV + 3, 1'b1);
    idle(DIGITS * SCAN_DIV + 1, 1'b0);

    step(1'b0, 1'b1, 1'b0, 0, 1'b1);
    strobe(4, 1'b1); strobe(0, 1'b1); strobe(7, 1'b1);
    idle(DIGITS * SCAN_DIV + 2, 1'b1);

    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    strobe(9, 1'b0); strobe(0, 1'b0); strobe(0, 1'b0); strobe(0, 1'b0);
    chk("ovf_before", 32'(ovf), 32'd0);
    strobe(1, 1'b0);
    chk("ovf_after", 32'(ovf), 32'd1);
    idle(5, 1'b0);
    step(1'b0, 1'b1, 1'b1, 6, 1'b0);
    chk("ovf_cleared", 32'(ovf), 32'd0);
    idle(DIGITS * SCAN_DIV, 1'b1);

    strobe(12, 1'b0);
    idle(DIGITS * SCAN_DIV, 1'b0);
    strobe(15, 1'b0);
    idle(DIGITS * SCAN_DIV, 1'b1);

    // Mid-scan reset loses buffer contents
    strobe(8, 1'b0);
    idle(5, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle(DIGITS * SCAN_DIV, 1'b0);

    for (int k = 0; k < 3000; k++) begin
      bit r_rst, r_clr, r_vld, r_blz;
      int r_val;
      r_rst = ($urandom_range(0, 299) == 0);
      r_clr = ($urandom_range(0, 49) == 0);
      r_vld = ($urandom_range(0, 9) < 3);
      r_val = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
      r_blz = ($urandom_range(0, 3) != 0);
      step(r_rst, r_clr, r_vld, r_val, r_blz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
